// File: rtl/eth_axis_frame_gen.sv
// eth_axis_frame_gen: AXI4-Stream Ethernet frame source for MAC/PCS transmit
// bring-up, loopback and latency tests. Builds frames from a latched
// dst/src/ethertype header plus generated payload, 8 bytes per beat, and
// never drops tvalid inside a frame.
// Optional feature macro: ETH_FRAME_GEN_PRBS_EN selects PRBS31 payload
// instead of the default incrementing payload.
module eth_axis_frame_gen #(
  parameter int MAX_FRAME_BYTES = 1514,
  parameter int IFG_CYCLES      = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [10:0] i_frame_len,
  input  logic [15:0] i_frame_count,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [15:0] i_ethertype,
  output logic [63:0] m00_axis_tdata,
  output logic [7:0]  m00_axis_tkeep,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic        m00_axis_tlast,
  output logic        o_busy,
  output logic [31:0] o_frames_sent
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  localparam logic [10:0] MIN_LEN = 11'd60;
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);
  localparam int          GAP_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  // Clamp a requested length into the legal Ethernet range.
  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    logic [10:0] r;
    r = len;
    if (len < MIN_LEN) r = MIN_LEN;
    else if (len > MAX_LEN) r = MAX_LEN;
    return r;
  endfunction

  // ceil(len/8)
  function automatic logic [8:0] beat_count(input logic [10:0] len);
    logic [11:0] sum;
    sum = {1'b0, len} + 12'd7;
    return sum[11:3];
  endfunction

  // Returns {tkeep, tdata} of one beat: header bytes, then incrementing
  // payload; bytes past the frame end are zero with their keep bit clear.
  function automatic logic [71:0] build_beat(input logic [111:0] hdr,
                                             input logic [10:0]  len,
                                             input logic [7:0]   seq,
                                             input logic [8:0]   beat);
    logic [63:0] data;
    logic [7:0]  keep;
    int          kk;
    data = '0;
    keep = '0;
    for (int j = 0; j < 8; j++) begin
      kk = int'(beat) * 8 + j;
      if (kk < int'(len)) begin
        keep[j] = 1'b1;
        if (kk < 14) data[8*j +: 8] = hdr[111 - 8*kk -: 8];
        else         data[8*j +: 8] = 8'(kk - 14) + seq;
      end
    end
    return {keep, data};
  endfunction

`ifdef ETH_FRAME_GEN_PRBS_EN
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  // PRBS31 (x^31 + x^28 + 1): state after 64 steps.
  function automatic logic [30:0] prbs_adv(input logic [30:0] s);
    logic [30:0] st;
    st = s;
    for (int i = 0; i < 64; i++) st = {st[29:0], st[30] ^ st[27]};
    return st;
  endfunction

  // PRBS31: the 64 output bits generated from state s, first bit in [0].
  function automatic logic [63:0] prbs_word(input logic [30:0] s);
    logic [30:0] st;
    logic [63:0] w;
    st = s;
    w  = '0;
    for (int i = 0; i < 64; i++) begin
      w[i] = st[30] ^ st[27];
      st   = {st[29:0], w[i]};
    end
    return w;
  endfunction

  // Replace payload bytes of beats 1.. with the PRBS word.
  function automatic logic [63:0] prbs_overlay(input logic [63:0] data,
                                               input logic [7:0]  keep,
                                               input logic [8:0]  beat,
                                               input logic [63:0] word);
    logic [63:0] d;
    d = data;
    if (beat != 9'd0) begin
      for (int j = 0; j < 8; j++) begin
        if (keep[j] && (int'(beat) * 8 + j >= 14)) d[8*j +: 8] = word[8*j +: 8];
      end
    end
    return d;
  endfunction
`endif

  state_t             state_q, state_d;
  logic [111:0]       hdr_q, hdr_in, hdr_sel;
  logic [10:0]        len_q, len_in, len_sel;
  logic [15:0]        count_q, seq_q, seq_d;
  logic [8:0]         beat_q, beat_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               stop_pend_q, stop_pend_d;
  logic               vld_d, load, use_in, sent_inc;
  logic               hs, burst_end, stop_now;
  logic [63:0]        beat_data, beat_raw;
  logic [7:0]         beat_keep;
  logic               beat_last;
  logic [63:0]        tdata_q;
  logic [7:0]         tkeep_q;
  logic               tvalid_q, tlast_q, busy_q;
  logic [31:0]        sent_q;

  assign hdr_in  = {i_dst_mac, i_src_mac, i_ethertype};
  assign len_in  = clamp_len(i_frame_len);
  assign hdr_sel = use_in ? hdr_in : hdr_q;
  assign len_sel = use_in ? len_in : len_q;

  // Next-state, beat sequencing and stop handling.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    seq_d     = seq_q;
    gap_d     = gap_q;
    vld_d     = tvalid_q;
    load      = 1'b0;
    use_in    = 1'b0;
    sent_inc  = 1'b0;
    hs        = tvalid_q & m00_axis_tready;
    burst_end = (count_q != 16'd0) && ((seq_q + 16'd1) == count_q);
    stop_now  = stop_pend_q | i_stop;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SEND;
          load    = 1'b1;
          use_in  = 1'b1;
          beat_d  = 9'd0;
          seq_d   = 16'd0;
          vld_d   = 1'b1;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (tlast_q) begin
            sent_inc = 1'b1;
            seq_d    = seq_q + 16'd1;
            if (stop_now || burst_end) begin
              state_d = ST_IDLE;
              vld_d   = 1'b0;
            end else if (IFG_CYCLES == 0) begin
              load   = 1'b1;
              beat_d = 9'd0;
            end else begin
              state_d = ST_GAP;
              gap_d   = '0;
              vld_d   = 1'b0;
            end
          end else begin
            load   = 1'b1;
            beat_d = beat_q + 9'd1;
          end
        end
      end
      ST_GAP: begin
        if (stop_now) begin
          state_d = ST_IDLE;
        end else if (int'(gap_q) == IFG_CYCLES - 1) begin
          state_d = ST_SEND;
          load    = 1'b1;
          beat_d  = 9'd0;
          vld_d   = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE)                  stop_pend_d = 1'b0;
    else if (i_stop && state_q != ST_IDLE)   stop_pend_d = 1'b1;
    else                                     stop_pend_d = stop_pend_q;
  end

  // Content of the beat being loaded this cycle.
  always_comb begin
    {beat_keep, beat_raw} = build_beat(hdr_sel, len_sel, seq_d[7:0], beat_d);
    beat_last             = (beat_d == beat_count(len_sel) - 9'd1);
  end

`ifdef ETH_FRAME_GEN_PRBS_EN
  logic [30:0] lfsr_q, lfsr_base;

  // LFSR state for the loaded beat: seed at beat 0/1, then 64 bits per beat.
  always_comb begin
    if (beat_d == 9'd0)      lfsr_base = PRBS_SEED;
    else if (beat_d == 9'd1) lfsr_base = lfsr_q;
    else                     lfsr_base = prbs_adv(lfsr_q);
    beat_data = prbs_overlay(beat_raw, beat_keep, beat_d, prbs_word(lfsr_base));
  end

  // LFSR state tracks the beat currently on the bus.
  always_ff @(posedge i_clk) begin
    if (load) lfsr_q <= lfsr_base;
  end
`else
  assign beat_data = beat_raw;
`endif

  // Burst parameters captured on an accepted start.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_IDLE && i_start) begin
      hdr_q <= hdr_in;
      len_q <= len_in;
    end
  end

  // Control state and registered AXIS outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      seq_q       <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      stop_pend_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      sent_q      <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      stop_pend_q <= stop_pend_d;
      tvalid_q    <= vld_d;
      busy_q      <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && i_start) count_q <= i_frame_count;
      if (sent_inc) sent_q <= sent_q + 32'd1;
      if (load) begin
        tdata_q <= beat_data;
        tkeep_q <= beat_keep;
        tlast_q <= beat_last;
      end else if (!vld_d) begin
        tdata_q <= '0;
        tkeep_q <= '0;
        tlast_q <= 1'b0;
      end
    end
  end

  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tkeep  = tkeep_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign o_busy          = busy_q;
  assign o_frames_sent   = sent_q;

endmodule

// File: tb/tb_eth_axis_frame_gen.sv
// Directed testbench for eth_axis_frame_gen (default incrementing payload).
// Two instances: dut with IFG_CYCLES=2, dut0 with IFG_CYCLES=0.
module tb_eth_axis_frame_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start0 = 1'b0, stop = 1'b0, tready = 1'b1;
  logic [10:0] flen = 11'd60;
  logic [15:0] fcount = 16'd1;
  logic [47:0] dst = 48'h001122334455;
  logic [47:0] src = 48'h66778899AABB;
  logic [15:0] etype = 16'h0800;

  logic [63:0] tdata, tdata0;
  logic [7:0]  tkeep, tkeep0;
  logic        tvalid, tvalid0, tlast, tlast0, busy, busy0;
  logic [31:0] sent, sent0;

  always #5 clk = ~clk;

  eth_axis_frame_gen #(.MAX_FRAME_BYTES(1514), .IFG_CYCLES(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_stop(stop),
    .i_frame_len(flen), .i_frame_count(fcount), .i_dst_mac(dst),
    .i_src_mac(src), .i_ethertype(etype), .m00_axis_tdata(tdata),
    .m00_axis_tkeep(tkeep), .m00_axis_tvalid(tvalid),
    .m00_axis_tready(tready), .m00_axis_tlast(tlast), .o_busy(busy),
    .o_frames_sent(sent));

  eth_axis_frame_gen #(.MAX_FRAME_BYTES(1514), .IFG_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start0), .i_stop(stop),
    .i_frame_len(flen), .i_frame_count(fcount), .i_dst_mac(dst),
    .i_src_mac(src), .i_ethertype(etype), .m00_axis_tdata(tdata0),
    .m00_axis_tkeep(tkeep0), .m00_axis_tvalid(tvalid0),
    .m00_axis_tready(tready), .m00_axis_tlast(tlast0), .o_busy(busy0),
    .o_frames_sent(sent0));

  bit          use0 = 1'b0;
  logic [63:0] c_data;
  logic [7:0]  c_keep;
  logic        c_valid, c_last;
  assign c_data  = use0 ? tdata0  : tdata;
  assign c_keep  = use0 ? tkeep0  : tkeep;
  assign c_valid = use0 ? tvalid0 : tvalid;
  assign c_last  = use0 ? tlast0  : tlast;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] rx_data [0:255];
  logic [7:0]  rx_keep [0:255];
  int          rx_n, rx_start, rx_end;
  bit          rx_gap_err, rx_stab_err, rx_to;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [10:0] l, input logic [15:0] c, input bit on0);
    flen   = l;
    fcount = c;
    if (on0) start0 = 1'b1;
    else     start  = 1'b1;
    step();
    start  = 1'b0;
    start0 = 1'b0;
  endtask

  // Collects one frame from the selected instance; returns one cycle after
  // the tlast handshake. Pulses stop when beat stop_beat is accepted.
  task automatic recv_frame(input int budget, input bit bp, input int stop_beat);
    int          waited;
    bit          in_frame, prev_stall, done;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    rx_n = 0; rx_gap_err = 0; rx_stab_err = 0; rx_to = 0;
    in_frame = 0; prev_stall = 0; done = 0; waited = 0;
    pd = '0; pk = '0; pl = 1'b0;
    while (!done && !rx_to) begin
      if (waited >= budget) begin
        rx_to = 1;
      end else begin
        stop   = 1'b0;
        tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (prev_stall && (c_valid !== 1'b1 || c_data !== pd || c_keep !== pk || c_last !== pl))
          rx_stab_err = 1;
        if (in_frame && c_valid !== 1'b1) rx_gap_err = 1;
        prev_stall = 0;
        if (c_valid === 1'b1) begin
          if (!in_frame) rx_start = cyc;
          in_frame = 1;
          if (tready) begin
            if (rx_n < 256) begin
              rx_data[rx_n] = c_data;
              rx_keep[rx_n] = c_keep;
            end
            if (rx_n == stop_beat) stop = 1'b1;
            rx_n++;
            if (c_last === 1'b1) begin
              rx_end = cyc;
              done   = 1;
            end
          end else begin
            prev_stall = 1;
            pd = c_data; pk = c_keep; pl = c_last;
          end
        end
        step();
        waited++;
      end
    end
    stop   = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++; if (tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %0h want 0", tvalid); end
    n_cmp++; if (tdata !== 64'd0) begin n_err++; $display("FAIL rst_tdata: got %0h want 0", tdata); end
    n_cmp++; if (tkeep !== 8'd0) begin n_err++; $display("FAIL rst_tkeep: got %0h want 0", tkeep); end
    n_cmp++; if (tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %0h want 0", tlast); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0h want 0", busy); end
    n_cmp++; if (sent !== 32'd0) begin n_err++; $display("FAIL rst_sent: got %0h want 0", sent); end
    rst_n = 1'b1;
    step(); step();
    n_cmp++; if (tvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_after_rst: got valid=%0h busy=%0h want 0 0", tvalid, busy); end
  endtask

  task automatic test_min_frame();
    use0 = 0;
    start_burst(11'd60, 16'd1, 0);
    n_cmp++; if (tvalid !== 1'b1) begin n_err++; $display("FAIL start_latency: got tvalid=%0h want 1", tvalid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_rise: got %0h want 1", busy); end
    recv_frame(50, 0, -1);
    n_cmp++; if (rx_to !== 1'b0) begin n_err++; $display("FAIL min_timeout: got %0h want 0", rx_to); end
    n_cmp++; if (rx_n !== 8) begin n_err++; $display("FAIL min_beats: got %0d want 8", rx_n); end
    n_cmp++; if (rx_data[0] !== 64'h7766554433221100) begin n_err++; $display("FAIL min_beat0: got %h want 7766554433221100", rx_data[0]); end
    n_cmp++; if (rx_data[1] !== 64'h01000008BBAA9988) begin n_err++; $display("FAIL min_beat1: got %h want 01000008bbaa9988", rx_data[1]); end
    n_cmp++; if (rx_keep[7] !== 8'h0F) begin n_err++; $display("FAIL min_last_keep: got %h want 0f", rx_keep[7]); end
    n_cmp++; if (rx_data[7] !== 64'h000000002D2C2B2A) begin n_err++; $display("FAIL min_last_data: got %h want 000000002d2c2b2a", rx_data[7]); end
    n_cmp++; if (sent !== 32'd1) begin n_err++; $display("FAIL min_sent: got %0d want 1", sent); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL min_busy_fall: got %0h want 0", busy); end
  endtask

  task automatic test_len_clamp();
    logic [10:0] lens  [0:2];
    int          beats [0:2];
    logic [7:0]  keeps [0:2];
    lens[0] = 11'd64;   beats[0] = 8;   keeps[0] = 8'hFF;
    lens[1] = 11'd10;   beats[1] = 8;   keeps[1] = 8'h0F;
    lens[2] = 11'd2000; beats[2] = 190; keeps[2] = 8'h03;
    use0 = 0;
    for (int i = 0; i < 3; i++) begin
      start_burst(lens[i], 16'd1, 0);
      recv_frame(300, 0, -1);
      n_cmp++; if (rx_n !== beats[i]) begin n_err++; $display("FAIL clamp_beats[%0d]: got %0d want %0d", i, rx_n, beats[i]); end
      n_cmp++; if (rx_keep[beats[i]-1] !== keeps[i]) begin n_err++; $display("FAIL clamp_keep[%0d]: got %h want %h", i, rx_keep[beats[i]-1], keeps[i]); end
    end
    n_cmp++; if (rx_data[189] !== 64'h000000000000DBDA) begin n_err++; $display("FAIL max_last_data: got %h want 000000000000dbda", rx_data[189]); end
    n_cmp++; if (sent !== 32'd4) begin n_err++; $display("FAIL clamp_sent: got %0d want 4", sent); end
  endtask

  task automatic test_backpressure();
    use0 = 0;
    start_burst(11'd100, 16'd4, 0);
    for (int f = 0; f < 4; f++) begin
      recv_frame(200, 1, -1);
      n_cmp++; if (rx_to !== 1'b0) begin n_err++; $display("FAIL bp_timeout[%0d]: got %0h want 0", f, rx_to); end
      n_cmp++; if (rx_n !== 13) begin n_err++; $display("FAIL bp_beats[%0d]: got %0d want 13", f, rx_n); end
      n_cmp++; if (rx_keep[12] !== 8'h0F) begin n_err++; $display("FAIL bp_keep[%0d]: got %h want 0f", f, rx_keep[12]); end
      n_cmp++; if (rx_gap_err !== 1'b0) begin n_err++; $display("FAIL bp_tvalid_gap[%0d]: got %0h want 0", f, rx_gap_err); end
      n_cmp++; if (rx_stab_err !== 1'b0) begin n_err++; $display("FAIL bp_stall_hold[%0d]: got %0h want 0", f, rx_stab_err); end
      n_cmp++; if (rx_data[1][55:48] !== 8'(f)) begin n_err++; $display("FAIL bp_seq_byte14[%0d]: got %h want %h", f, rx_data[1][55:48], 8'(f)); end
    end
    n_cmp++; if (sent !== 32'd8) begin n_err++; $display("FAIL bp_sent: got %0d want 8", sent); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy: got %0h want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int starts [0:2];
    int ends   [0:2];
    logic [7:0] b14;
    for (int d = 0; d < 2; d++) begin
      use0 = (d == 1);
      start_burst(11'd60, 16'd3, use0);
      b14 = 8'hXX;
      for (int f = 0; f < 3; f++) begin
        recv_frame(50, 0, -1);
        starts[f] = rx_start;
        ends[f]   = rx_end;
        if (f == 1) b14 = rx_data[1][55:48];
        n_cmp++; if (rx_n !== 8) begin n_err++; $display("FAIL ifg%0d_beats[%0d]: got %0d want 8", d, f, rx_n); end
      end
      for (int f = 1; f < 3; f++) begin
        n_cmp++;
        if (starts[f] - ends[f-1] - 1 !== (d == 0 ? 2 : 0)) begin
          n_err++; $display("FAIL ifg%0d_idle[%0d]: got %0d want %0d", d, f, starts[f] - ends[f-1] - 1, (d == 0 ? 2 : 0));
        end
      end
      n_cmp++; if (b14 !== 8'h01) begin n_err++; $display("FAIL ifg%0d_frame1_byte14: got %h want 01", d, b14); end
    end
    n_cmp++; if (sent !== 32'd11) begin n_err++; $display("FAIL ifg_sent: got %0d want 11", sent); end
    n_cmp++; if (sent0 !== 32'd3) begin n_err++; $display("FAIL ifg0_sent: got %0d want 3", sent0); end
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL ifg0_busy: got %0h want 0", busy0); end
    use0 = 0;
  endtask

  task automatic test_stop();
    bit any_to, seen;
    use0 = 0;
    any_to = 0;
    start_burst(11'd60, 16'd0, 0);
    for (int f = 0; f < 6; f++) begin
      recv_frame(50, 0, (f == 5) ? 3 : -1);
      if (rx_to) any_to = 1;
    end
    n_cmp++; if (any_to !== 1'b0) begin n_err++; $display("FAIL stop_timeout: got %0h want 0", any_to); end
    n_cmp++; if (rx_n !== 8 || rx_keep[7] !== 8'h0F) begin n_err++; $display("FAIL stop_frame5: got beats=%0d keep=%h want 8 0f", rx_n, rx_keep[7]); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %0h want 0", busy); end
    n_cmp++; if (sent !== 32'd17) begin n_err++; $display("FAIL stop_sent: got %0d want 17", sent); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (tvalid !== 1'b0) seen = 1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL stop_no_frame6: got %0h want 0", seen); end
  endtask

  task automatic test_reset_mid();
    use0 = 0;
    start_burst(11'd60, 16'd1, 0);
    step(); step(); step();
    n_cmp++; if (tdata !== 64'h11100F0E0D0C0B0A) begin n_err++; $display("FAIL mid_beat3: got %h want 11100f0e0d0c0b0a", tdata); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tvalid !== 1'b0 || tlast !== 1'b0) begin n_err++; $display("FAIL async_valid_last: got %0h %0h want 0 0", tvalid, tlast); end
    n_cmp++; if (tdata !== 64'd0 || tkeep !== 8'd0) begin n_err++; $display("FAIL async_data_keep: got %h %h want 0 0", tdata, tkeep); end
    n_cmp++; if (busy !== 1'b0 || sent !== 32'd0) begin n_err++; $display("FAIL async_busy_sent: got %0h %0d want 0 0", busy, sent); end
    step();
    rst_n = 1'b1;
    step();
    start_burst(11'd60, 16'd1, 0);
    n_cmp++; if (tdata !== 64'h7766554433221100) begin n_err++; $display("FAIL restart_beat0: got %h want 7766554433221100", tdata); end
    recv_frame(50, 0, -1);
    n_cmp++; if (rx_n !== 8 || rx_data[1][55:48] !== 8'h00) begin n_err++; $display("FAIL restart_seq: got beats=%0d byte14=%h want 8 00", rx_n, rx_data[1][55:48]); end
    n_cmp++; if (sent !== 32'd1) begin n_err++; $display("FAIL restart_sent: got %0d want 1", sent); end
  endtask

  initial begin
    #1;
    test_reset();
    test_min_frame();
    test_len_clamp();
    test_backpressure();
    test_back_to_back();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eth_axis_frame_gen.md
# eth_axis_frame_gen

AXI4-Stream frame source that drives the MAC/PCS transmit AXIS slave (`s00_axis_*`) with Ethernet frames for bring-up, loopback and latency tests. It builds each frame from a programmable header and a generated payload, and respects `tready` back-pressure without ever creating a mid-frame `tvalid` gap, since the low-latency MAC has no underrun tolerance. It sits in the transmit user-clock domain (`s00_axis_aclk`), opposite the MAC's AXIS slave port.

## Interface
Parameters:
- `MAX_FRAME_BYTES`, 1514: upper clamp on frame length, header included, FCS excluded.
- `IFG_CYCLES`, 2: idle cycles (`tvalid`=0) between consecutive frames of a burst; 0 means back-to-back.

Ports:
- `i_clk`  in  1  transmit user clock; the same clock as `s00_axis_aclk`.
- `i_reset_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  single-cycle pulse that begins a burst; ignored while `o_busy`=1.
- `i_stop`  in  1  pulse; ends the burst after the current frame completes.
- `i_frame_len`  in  11  frame bytes excluding FCS; latched on `i_start`, clamped to [60, `MAX_FRAME_BYTES`].
- `i_frame_count`  in  16  frames per burst; latched on `i_start`; 0 means continuous until `i_stop`.
- `i_dst_mac`  in  48  destination MAC; byte 0 on the wire is `[47:40]`.
- `i_src_mac`  in  48  source MAC; same byte order as `i_dst_mac`.
- `i_ethertype`  in  16  ethertype; `[15:8]` goes first.
- `m00_axis_tdata`  out  64  `[7:0]` is the first byte on the wire.
- `m00_axis_tkeep`  out  8  contiguous from bit 0.
- `m00_axis_tvalid`  out  1
- `m00_axis_tready`  in  1
- `m00_axis_tlast`  out  1
- `o_busy`  out  1  high from the cycle after an accepted `i_start` until return to IDLE.
- `o_frames_sent`  out  32  count of completed frames; wraps; clears only on reset.

## Operation
- Header fields are latched on `i_start`.
- Frame byte k is assigned as follows:
  - k=0..5: destination MAC.
  - k=6..11: source MAC.
  - k=12..13: ethertype.
  - k≥14: payload.
- Beat b carries bytes 8b..8b+7.
- Beats per frame: N = ceil(L/8), where L is the clamped length.
  - Beats 0..N-2 have `tkeep`=0xFF.
  - Beat N-1 has `tkeep` = (1<<(L mod 8))-1, or 0xFF when L mod 8 = 0, and `tlast`=1.
  - Bytes outside `tkeep` are driven 0.
- Default payload byte value is (k-14 + seq[7:0]) mod 256, where seq is the frame index within the burst, starting at 0.
- State machine:
  - IDLE → SEND on `i_start`.
  - SEND → GAP on the `tlast` handshake, when further frames remain and `IFG_CYCLES`>0.
  - SEND → SEND on the `tlast` handshake, when further frames remain and `IFG_CYCLES`=0.
  - SEND → IDLE on the `tlast` handshake, when the burst is done or a stop is pending.
  - GAP → SEND after `IFG_CYCLES` cycles.
  - GAP → IDLE immediately if a stop is pending.
- `i_stop` sets a sticky stop-pending flag, cleared on entry to IDLE.
  - A stop in IDLE is ignored.
  - A stop coinciding with the `tlast` handshake prevents the next frame.
- AXIS rule: once `tvalid`=1, `tdata`/`tkeep`/`tlast` hold until `tready`=1. `tvalid` stays 1 for every beat of a frame.

## Timing
- All outputs are registered.
- Reset values: `tvalid`=0, `tdata`=0, `tkeep`=0, `tlast`=0, `o_busy`=0, `o_frames_sent`=0, FSM=IDLE.
- `i_start` in cycle t → `tvalid`=1 with beat 0 in cycle t+1.
- Throughput is 1 beat/cycle while `tready`=1.
- Inter-frame gap: after the `tlast` handshake in cycle t, `tvalid`=0 for cycles t+1..t+`IFG_CYCLES`, and the next beat 0 appears at t+`IFG_CYCLES`+1.
- `o_frames_sent` increments in the cycle after each `tlast` handshake.
- `o_busy` falls in the cycle after the final `tlast` handshake.
- Asserting `i_reset_n` low mid-frame clears all outputs asynchronously. No resume: the truncated frame is abandoned.

## Configuration
- `ETH_FRAME_GEN_PRBS_EN` defined: payload bytes come from a PRBS31 LFSR (x^31+x^28+1).
  - The LFSR is seeded to 0x7FFFFFFF at each beat 0.
  - It advances 64 bits per accepted beat from beat 1 onward.
  - Payload byte k in beat b≥1 is `lfsr[8*(k mod 8)+:8]`.
  - Payload bytes 14,15 in beat 1 also use the LFSR.
- `ETH_FRAME_GEN_PRBS_EN` undefined: incrementing payload as described in Operation; no LFSR logic is synthesised.

## Test plan
- Min frame, back-pressure-free: L=60, count=1, `tready`=1, dst=0x001122334455, src=0x66778899AABB → 8 beats, beat0 `tdata`=0x7766554433221100, last `tkeep`=0x0F, `o_frames_sent`=1.
- Exact multiple and clamps:
  - L=64 → last `tkeep`=0xFF.
  - L=10 → 8 beats (clamped to 60).
  - L=2000 → 190 beats, last `tkeep`=0x03 (1514).
- Back-pressure: random `tready` with 50% duty, count=4, L=100 → no `tvalid` drop mid-frame, outputs stable while stalled, 13 beats per frame, `o_frames_sent`=4.
- Inter-frame gap:
  - `IFG_CYCLES`=2, count=3 → exactly 2 idle cycles between frames.
  - `IFG_CYCLES`=0 → beat 0 of the next frame directly follows `tlast`.
  - Frame 1 payload byte 14 = 0x01.
- Continuous and stop: count=0, `i_stop` pulsed mid-frame 5 → frame 5 completes with `tlast`, no frame 6, `o_busy`=0 one cycle later.
- Reset mid-frame: `i_reset_n` low during beat 3 → all outputs 0 immediately. A new `i_start` then produces a fresh beat 0 with seq=0.
